sb_1mns_xbar: RTL and testbench
===============================

Name: sb_1mns_xbar

Overview:
- Parametrised single-master, NS-slave simple-bus interconnect; next generation of the fixed 1-master/4-slave splitter.
- Decode is programmable: base/mask per slave. Unmatched addresses go to an internal default slave that returns an error.
- Read and write paths are independent. Each allows up to OUTSTANDING in-flight transactions to the same target, with in-order responses.
- Sits between the RV32I core data/instruction master port and the peripheral/memory slaves.

Parameters:
NS, 4, number of slaves (1..8).
OUTSTANDING, 2, max in-flight transactions per path (1..15).
SLV_BASE, {32'h4000_0000,32'h2000_0000,32'h1000_0000,32'h0000_0000}, flattened NS*32 base addresses; slave i in bits [32i+31:32i].
SLV_MASK, {4{32'hF000_0000}}, flattened NS*32 decode masks.
ERR_RDATA, 32'hDEAD_BEEF, read data returned on decode error.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
sb_arvalid_m0/sb_arready_m0/sb_araddr_m0  in/out/in  1/1/32  master read address
sb_rvalid_m0/sb_rready_m0/sb_rdata_m0  out/in/out  1/1/32  master read data
sb_wvalid_m0/sb_wready_m0/sb_waddr_m0/sb_wdata_m0/sb_wstrb_m0  in/out/in/in/in  1/1/32/32/4  master write
sb_bvalid_m0/sb_bready_m0/sb_bresp_m0  out/in/out  1/1/1  master write response; 1=error
sb_arvalid_s/sb_arready_s/sb_araddr_s  out/in/out  NS/NS/NS*32  slave read address, bit/slice i = slave i
sb_rvalid_s/sb_rready_s/sb_rdata_s  in/out/in  NS/NS/NS*32  slave read data
sb_wvalid_s/sb_wready_s/sb_waddr_s/sb_wdata_s/sb_wstrb_s  out/in/out/out/out  NS/NS/NS*32/NS*32/NS*4  slave write
sb_bvalid_s/sb_bready_s/sb_bresp_s  in/out/in  NS/NS/NS  slave write response
decerr_o  out  1  one-cycle pulse when a request is accepted to the default slave

Behaviour:
- Decode: slave i matches when (addr & MASK_i) == BASE_i. The lowest matching index wins. No match selects target NS (default slave). Decode is combinational on the current master address.
- Per path (read shown; write identical with w/b in place of ar/r):
  - State: cnt (0..OUTSTANDING) and cur_tgt (index 0..NS).
  - Forwarding is allowed (gate=1) when cnt==0; or cnt<OUTSTANDING and tgt==cur_tgt; or cnt==1 and r_ok this cycle, which permits a target switch.
  - sb_arvalid_s[tgt] = arvalid_m0 & gate. All other arvalid_s bits are 0.
  - arready_m0 = gate & (selected slave's arready, or 1 for the default slave).
  - ar_ok=arvalid&arready; r_ok=rvalid_m0&rready_m0.
  - cnt: +1 on ar_ok only; -1 on r_ok only; unchanged on both.
  - cur_tgt loads tgt on every ar_ok.
  - Response mux is selected by cur_tgt while cnt>0. rvalid_m0=0 when cnt==0.
  - rready_s[cur_tgt]=rready_m0 when cnt>0; all other bits are 0.
- Address, wdata and wstrb are broadcast to all slaves unmodified.
- Default slave:
  - Holds its own pending counter, incremented by ar_ok to target NS and decremented on r_ok.
  - Asserts rvalid while pending>0, with rdata=ERR_RDATA. First response appears the cycle after acceptance.
  - Write equivalent: bvalid with bresp=1.
- decerr_o pulses in the cycle of ar_ok or w_ok to target NS. It pulses twice if both occur in the same cycle.
- Master handshakes are never combinationally dependent on master valid→ready loops, except through the slave's own ready.
- Slave responses arriving when not selected are ignored (held by the slave, rready 0).
- Reset:
  - cnt=0, cur_tgt=0, default-slave counters=0.
  - All outputs driven low: arvalid_s, wvalid_s, rvalid_m0, bvalid_m0, decerr_o, arready_m0/wready_m0 low while rst.
  - Reset mid-transaction drops all in-flight state. Slaves must be reset in the same domain.
- Counter never exceeds OUTSTANDING; gate is 0 at full.

Test Plan:
- Read 0x1000_0004 with slave1 arready=1, rvalid one cycle later with rdata=0x1234_5678 → arvalid_s=4'b0010; rdata_m0=0x1234_5678; cnt goes 0→1→0.
- Two back-to-back reads to 0x0000_0000 and 0x0000_0010, slave0 slow response → both accepted, since OUTSTANDING=2. Third read stalls with arready_m0=0 until the first r_ok.
- Read to slave2, then read to slave0 while slave2 response is pending → slave0 arvalid held 0. It forwards in the same cycle as slave2's r_ok; cur_tgt becomes 0.
- Write 0x8000_0000, wdata=0xA5A5_A5A5, wstrb=4'hF → no wvalid_s bit set; decerr_o pulses once; bvalid_m0 next cycle with bresp=1.
- Read 0x9000_0000 → rdata_m0=0xDEAD_BEEF one cycle after acceptance; decerr_o=1 for one cycle.
- Assert rst while cnt=2 on the write path → bvalid_m0=0 and wvalid_s=0 immediately. After release, a write to slave3 (0x4000_0000) proceeds normally.

Source files
------------

// File: rtl/sb_1mns_xbar.sv
// Single-master, NS-slave simple-bus interconnect with programmable base/mask decode,
// independent read/write paths and an internal default slave that answers with an error.

module sb_1mns_path #(
  parameter int              NS          = 4,
  parameter int              OUTSTANDING = 2,
  parameter logic [NS*32-1:0] SLV_BASE   = '0,
  parameter logic [NS*32-1:0] SLV_MASK   = '0,
  parameter int              PW          = 32,
  parameter logic [PW-1:0]   ERR_PAYLOAD = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  output logic [NS-1:0]    req_valid_s,
  input  logic [NS-1:0]    req_ready_s,
  input  logic [NS-1:0]    rsp_valid_s,
  output logic [NS-1:0]    rsp_ready_s,
  input  logic [NS*PW-1:0] rsp_payload_s,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [PW-1:0]    rsp_payload,
  output logic             dec_ok
);
  localparam int TW = $clog2(NS + 1);
  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam logic [TW-1:0] DFLT = TW'(NS);
  localparam logic [CW-1:0] FULL = CW'(OUTSTANDING);

  logic [TW-1:0] tgt;
  logic [TW-1:0] cur_tgt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] dflt_cnt;
  logic          found;
  logic          sel_ready;
  logic          gate;
  logic          req_ok;
  logic          rsp_ok;
  logic          dflt_rsp;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    tgt   = DFLT;
    found = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (!found && ((req_addr & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32])) begin
        tgt   = TW'(i);
        found = 1'b1;
      end
    end
  end

  // Responses come only from the target currently owning the path; others are held off.
  always_comb begin
    rsp_valid   = 1'b0;
    rsp_payload = ERR_PAYLOAD;
    rsp_ready_s = '0;
    if (cnt != '0) begin
      if (cur_tgt == DFLT) begin
        rsp_valid = (dflt_cnt != '0);
      end
      for (int i = 0; i < NS; i++) begin
        if (cur_tgt == TW'(i)) begin
          rsp_valid      = rsp_valid_s[i];
          rsp_payload    = rsp_payload_s[i*PW +: PW];
          rsp_ready_s[i] = rsp_ready;
        end
      end
    end
  end

  assign rsp_ok   = rsp_valid & rsp_ready;
  assign dflt_rsp = rsp_ok & (cur_tgt == DFLT);

  // A target switch is only safe once the last response of the old target retires.
  assign gate = (cnt == '0)
              || ((cnt < FULL) && (tgt == cur_tgt))
              || ((cnt == CW'(1)) && rsp_ok);

  always_comb begin
    req_valid_s = '0;
    sel_ready   = 1'b1;
    for (int i = 0; i < NS; i++) begin
      if (tgt == TW'(i)) begin
        req_valid_s[i] = req_valid & gate & ~rst;
        sel_ready      = req_ready_s[i];
      end
    end
  end

  assign req_ready = gate & sel_ready & ~rst;
  assign req_ok    = req_valid & req_ready;
  assign dec_ok    = req_ok & (tgt == DFLT);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      cur_tgt  <= '0;
      dflt_cnt <= '0;
    end else begin
      if (req_ok && !rsp_ok) begin
        cnt <= cnt + CW'(1);
      end else if (!req_ok && rsp_ok) begin
        cnt <= cnt - CW'(1);
      end
      if (req_ok) begin
        cur_tgt <= tgt;
      end
      if (dec_ok && !dflt_rsp) begin
        dflt_cnt <= dflt_cnt + CW'(1);
      end else if (!dec_ok && dflt_rsp) begin
        dflt_cnt <= dflt_cnt - CW'(1);
      end
    end
  end
endmodule

module sb_1mns_xbar #(
  parameter int               NS          = 4,
  parameter int               OUTSTANDING = 2,
  parameter logic [NS*32-1:0] SLV_BASE    = {32'h4000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NS*32-1:0] SLV_MASK    = {4{32'hF000_0000}},
  parameter logic [31:0]      ERR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sb_arvalid_m0,
  output logic             sb_arready_m0,
  input  logic [31:0]      sb_araddr_m0,
  output logic             sb_rvalid_m0,
  input  logic             sb_rready_m0,
  output logic [31:0]      sb_rdata_m0,
  input  logic             sb_wvalid_m0,
  output logic             sb_wready_m0,
  input  logic [31:0]      sb_waddr_m0,
  input  logic [31:0]      sb_wdata_m0,
  input  logic [3:0]       sb_wstrb_m0,
  output logic             sb_bvalid_m0,
  input  logic             sb_bready_m0,
  output logic             sb_bresp_m0,
  output logic [NS-1:0]    sb_arvalid_s,
  input  logic [NS-1:0]    sb_arready_s,
  output logic [NS*32-1:0] sb_araddr_s,
  input  logic [NS-1:0]    sb_rvalid_s,
  output logic [NS-1:0]    sb_rready_s,
  input  logic [NS*32-1:0] sb_rdata_s,
  output logic [NS-1:0]    sb_wvalid_s,
  input  logic [NS-1:0]    sb_wready_s,
  output logic [NS*32-1:0] sb_waddr_s,
  output logic [NS*32-1:0] sb_wdata_s,
  output logic [NS*4-1:0]  sb_wstrb_s,
  input  logic [NS-1:0]    sb_bvalid_s,
  output logic [NS-1:0]    sb_bready_s,
  input  logic [NS-1:0]    sb_bresp_s,
  output logic             decerr_o
);
  logic       ar_dec;
  logic       w_dec;
  logic [1:0] dec_events;
  logic [3:0] owed_cnt;

  sb_1mns_path #(
    .NS(NS), .OUTSTANDING(OUTSTANDING), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK),
    .PW(32), .ERR_PAYLOAD(ERR_RDATA)
  ) u_rd (
    .clk(clk), .rst(rst),
    .req_valid(sb_arvalid_m0), .req_ready(sb_arready_m0), .req_addr(sb_araddr_m0),
    .req_valid_s(sb_arvalid_s), .req_ready_s(sb_arready_s),
    .rsp_valid_s(sb_rvalid_s), .rsp_ready_s(sb_rready_s), .rsp_payload_s(sb_rdata_s),
    .rsp_valid(sb_rvalid_m0), .rsp_ready(sb_rready_m0), .rsp_payload(sb_rdata_m0),
    .dec_ok(ar_dec)
  );

  sb_1mns_path #(
    .NS(NS), .OUTSTANDING(OUTSTANDING), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK),
    .PW(1), .ERR_PAYLOAD(1'b1)
  ) u_wr (
    .clk(clk), .rst(rst),
    .req_valid(sb_wvalid_m0), .req_ready(sb_wready_m0), .req_addr(sb_waddr_m0),
    .req_valid_s(sb_wvalid_s), .req_ready_s(sb_wready_s),
    .rsp_valid_s(sb_bvalid_s), .rsp_ready_s(sb_bready_s), .rsp_payload_s(sb_bresp_s),
    .rsp_valid(sb_bvalid_m0), .rsp_ready(sb_bready_m0), .rsp_payload(sb_bresp_m0),
    .dec_ok(w_dec)
  );

  assign sb_araddr_s = {NS{sb_araddr_m0}};
  assign sb_waddr_s  = {NS{sb_waddr_m0}};
  assign sb_wdata_s  = {NS{sb_wdata_m0}};
  assign sb_wstrb_s  = {NS{sb_wstrb_m0}};

  // Simultaneous read and write decode errors owe a second pulse on the following cycle.
  assign dec_events = {1'b0, ar_dec} + {1'b0, w_dec};
  assign decerr_o   = (dec_events != 2'd0) || (owed_cnt != 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owed_cnt <= 4'd0;
    end else if ((dec_events == 2'd2) && (owed_cnt != 4'hF)) begin
      owed_cnt <= owed_cnt + 4'd1;
    end else if ((dec_events == 2'd0) && (owed_cnt != 4'd0)) begin
      owed_cnt <= owed_cnt - 4'd1;
    end
  end
endmodule

// File: tb/tb_sb_1mns_xbar.sv
// Scoreboard bench for sb_1mns_xbar: directed master traffic against simple slave models,
// responses checked by independent monitors in arrival order.
`timescale 1ns/1ps
module tb_sb_1mns_xbar;
  localparam int NS = 4;

  logic             clk;
  logic             rst;
  logic             sb_arvalid_m0, sb_arready_m0;
  logic [31:0]      sb_araddr_m0;
  logic             sb_rvalid_m0, sb_rready_m0;
  logic [31:0]      sb_rdata_m0;
  logic             sb_wvalid_m0, sb_wready_m0;
  logic [31:0]      sb_waddr_m0, sb_wdata_m0;
  logic [3:0]       sb_wstrb_m0;
  logic             sb_bvalid_m0, sb_bready_m0, sb_bresp_m0;
  logic [NS-1:0]    sb_arvalid_s, sb_arready_s;
  logic [NS*32-1:0] sb_araddr_s;
  logic [NS-1:0]    sb_rvalid_s, sb_rready_s;
  logic [NS*32-1:0] sb_rdata_s;
  logic [NS-1:0]    sb_wvalid_s, sb_wready_s;
  logic [NS*32-1:0] sb_waddr_s, sb_wdata_s;
  logic [NS*4-1:0]  sb_wstrb_s;
  logic [NS-1:0]    sb_bvalid_s, sb_bready_s, sb_bresp_s;
  logic             decerr_o;

  sb_1mns_xbar dut (
    .clk(clk), .rst(rst),
    .sb_arvalid_m0(sb_arvalid_m0), .sb_arready_m0(sb_arready_m0), .sb_araddr_m0(sb_araddr_m0),
    .sb_rvalid_m0(sb_rvalid_m0), .sb_rready_m0(sb_rready_m0), .sb_rdata_m0(sb_rdata_m0),
    .sb_wvalid_m0(sb_wvalid_m0), .sb_wready_m0(sb_wready_m0), .sb_waddr_m0(sb_waddr_m0),
    .sb_wdata_m0(sb_wdata_m0), .sb_wstrb_m0(sb_wstrb_m0),
    .sb_bvalid_m0(sb_bvalid_m0), .sb_bready_m0(sb_bready_m0), .sb_bresp_m0(sb_bresp_m0),
    .sb_arvalid_s(sb_arvalid_s), .sb_arready_s(sb_arready_s), .sb_araddr_s(sb_araddr_s),
    .sb_rvalid_s(sb_rvalid_s), .sb_rready_s(sb_rready_s), .sb_rdata_s(sb_rdata_s),
    .sb_wvalid_s(sb_wvalid_s), .sb_wready_s(sb_wready_s), .sb_waddr_s(sb_waddr_s),
    .sb_wdata_s(sb_wdata_s), .sb_wstrb_s(sb_wstrb_s),
    .sb_bvalid_s(sb_bvalid_s), .sb_bready_s(sb_bready_s), .sb_bresp_s(sb_bresp_s),
    .decerr_o(decerr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  logic [31:0] rq[$];
  logic        bq[$];
  logic [75:0] wq[$];

  // Slave models: always ready, respond the cycle after acceptance unless held.
  logic [31:0] sdat [NS][16];
  logic [3:0]  wp [NS];
  logic [3:0]  rp [NS];
  logic [3:0]  rpend [NS];
  logic [3:0]  wpend [NS];
  logic [NS-1:0] rhold, bhold;

  assign sb_arready_s = '1;
  assign sb_wready_s  = '1;
  assign sb_bresp_s   = '0;

  for (genvar g = 0; g < NS; g++) begin : g_slv
    assign sb_rvalid_s[g]         = (rpend[g] != 4'd0) && !rhold[g];
    assign sb_rdata_s[g*32 +: 32] = sdat[g][rp[g]];
    assign sb_bvalid_s[g]         = (wpend[g] != 4'd0) && !bhold[g];
  end

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < NS; i++) begin
      if (rst) begin
        rpend[i] <= 4'd0;
        wpend[i] <= 4'd0;
        rp[i]    <= wp[i];
      end else begin
        rpend[i] <= rpend[i] + 4'(sb_arvalid_s[i] & sb_arready_s[i]) - 4'(sb_rvalid_s[i] & sb_rready_s[i]);
        wpend[i] <= wpend[i] + 4'(sb_wvalid_s[i] & sb_wready_s[i]) - 4'(sb_bvalid_s[i] & sb_bready_s[i]);
        if (sb_rvalid_s[i] && sb_rready_s[i]) rp[i] <= rp[i] + 4'd1;
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int s, input logic [31:0] d);
    sdat[s][wp[s]] = d;
    wp[s] = wp[s] + 4'd1;
  endtask

  // Monitors: compare master responses and slave-side write requests against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (sb_rvalid_m0 && sb_rready_m0) begin
        if (rq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rd_unexpected: got rdata %0h expected no response", sb_rdata_m0);
        end else begin
          check("rd_data", 128'(sb_rdata_m0), 128'(rq.pop_front()));
        end
      end
      if (sb_bvalid_m0 && sb_bready_m0) begin
        if (bq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL wr_unexpected: got bresp %0h expected no response", sb_bresp_m0);
        end else begin
          check("wr_bresp", 128'(sb_bresp_m0), 128'(bq.pop_front()));
        end
      end
      for (int i = 0; i < NS; i++) begin
        if (sb_wvalid_s[i] && sb_wready_s[i]) begin
          if (wq.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL slv_wr_unexpected: got write on slave %0d expected none", i);
          end else begin
            check("slv_wr", 128'({8'(i), sb_waddr_s[i*32 +: 32], sb_wdata_s[i*32 +: 32], sb_wstrb_s[i*4 +: 4]}),
                  128'(wq.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    n_checks = 0; n_fail = 0;
    sb_arvalid_m0 = 1'b0; sb_araddr_m0 = '0;
    sb_wvalid_m0 = 1'b0; sb_waddr_m0 = '0; sb_wdata_m0 = '0; sb_wstrb_m0 = '0;
    sb_rready_m0 = 1'b1; sb_bready_m0 = 1'b1;
    rhold = '0; bhold = '0;
    for (int i = 0; i < NS; i++) wp[i] = 4'd0;
    rst = 1'b0;

    // Reset with requests already asserted: nothing may leak through.
    sb_arvalid_m0 = 1'b1; sb_araddr_m0 = 32'h1000_0000;
    sb_wvalid_m0 = 1'b1; sb_waddr_m0 = 32'h9000_0000;
    #1 rst = 1'b1;
    #1;
    check("rst_arready", 128'(sb_arready_m0), 128'(0));
    check("rst_wready", 128'(sb_wready_m0), 128'(0));
    check("rst_arvalid_s", 128'(sb_arvalid_s), 128'(0));
    check("rst_wvalid_s", 128'(sb_wvalid_s), 128'(0));
    check("rst_rvalid", 128'(sb_rvalid_m0), 128'(0));
    check("rst_bvalid", 128'(sb_bvalid_m0), 128'(0));
    check("rst_decerr", 128'(decerr_o), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    sb_arvalid_m0 = 1'b0; sb_wvalid_m0 = 1'b0; rst = 1'b0;
    step();

    // Single read to slave 1.
    preload(1, 32'h1234_5678); rq.push_back(32'h1234_5678);
    sb_araddr_m0 = 32'h1000_0004; sb_arvalid_m0 = 1'b1; #1;
    check("t2_arvalid_s", 128'(sb_arvalid_s), 128'(4'b0010));
    check("t2_arready", 128'(sb_arready_m0), 128'(1));
    step(); sb_arvalid_m0 = 1'b0; #1;
    check("t2_rvalid_next", 128'(sb_rvalid_m0), 128'(1));
    step();
    check("t2_rvalid_done", 128'(sb_rvalid_m0), 128'(0));

    // Two outstanding reads to a slow slave 0, third stalls until the first retires.
    rhold[0] = 1'b1;
    preload(0, 32'h0A0A_0001); preload(0, 32'h0A0A_0002); preload(0, 32'h0A0A_0003);
    rq.push_back(32'h0A0A_0001); rq.push_back(32'h0A0A_0002); rq.push_back(32'h0A0A_0003);
    sb_araddr_m0 = 32'h0000_0000; sb_arvalid_m0 = 1'b1; #1;
    check("t3_acc1", 128'(sb_arready_m0), 128'(1));
    step(); sb_araddr_m0 = 32'h0000_0010; #1;
    check("t3_acc2", 128'(sb_arready_m0), 128'(1));
    step(); sb_araddr_m0 = 32'h0000_0020; #1;
    check("t3_full_arready", 128'(sb_arready_m0), 128'(0));
    check("t3_full_arvalid_s", 128'(sb_arvalid_s), 128'(0));
    step();
    check("t3_stall_arready", 128'(sb_arready_m0), 128'(0));
    rhold[0] = 1'b0; #1;
    check("t3_rok_arready", 128'(sb_arready_m0), 128'(0));
    check("t3_rok_rvalid", 128'(sb_rvalid_m0), 128'(1));
    step();
    check("t3_acc3", 128'(sb_arready_m0), 128'(1));
    step(); sb_arvalid_m0 = 1'b0;
    repeat (3) step();

    // Target switch from slave 2 to slave 0 only on slave 2's response.
    rhold[2] = 1'b1;
    preload(2, 32'h2222_0001); preload(0, 32'h0A0A_0004);
    rq.push_back(32'h2222_0001); rq.push_back(32'h0A0A_0004);
    sb_araddr_m0 = 32'h2000_0000; sb_arvalid_m0 = 1'b1; #1;
    check("t4_arvalid_s2", 128'(sb_arvalid_s), 128'(4'b0100));
    step(); sb_araddr_m0 = 32'h0000_0040; #1;
    check("t4_hold_arvalid_s", 128'(sb_arvalid_s), 128'(0));
    check("t4_hold_arready", 128'(sb_arready_m0), 128'(0));
    step();
    check("t4_hold2_arvalid_s", 128'(sb_arvalid_s), 128'(0));
    rhold[2] = 1'b0; #1;
    check("t4_switch_arvalid_s", 128'(sb_arvalid_s), 128'(4'b0001));
    check("t4_switch_arready", 128'(sb_arready_m0), 128'(1));
    step(); sb_arvalid_m0 = 1'b0; #1;
    check("t4_rvalid_s0", 128'(sb_rvalid_m0), 128'(1));
    repeat (2) step();

    // Unmapped write goes to the default slave.
    bq.push_back(1'b1);
    sb_waddr_m0 = 32'h8000_0000; sb_wdata_m0 = 32'hA5A5_A5A5; sb_wstrb_m0 = 4'hF; sb_wvalid_m0 = 1'b1; #1;
    check("t5_wvalid_s", 128'(sb_wvalid_s), 128'(0));
    check("t5_wready", 128'(sb_wready_m0), 128'(1));
    check("t5_decerr", 128'(decerr_o), 128'(1));
    step(); sb_wvalid_m0 = 1'b0; #1;
    check("t5_decerr_off", 128'(decerr_o), 128'(0));
    check("t5_bvalid", 128'(sb_bvalid_m0), 128'(1));
    step();
    check("t5_bvalid_off", 128'(sb_bvalid_m0), 128'(0));

    // Unmapped read returns the error word.
    rq.push_back(32'hDEAD_BEEF);
    sb_araddr_m0 = 32'h9000_0000; sb_arvalid_m0 = 1'b1; #1;
    check("t6_arvalid_s", 128'(sb_arvalid_s), 128'(0));
    check("t6_decerr", 128'(decerr_o), 128'(1));
    step(); sb_arvalid_m0 = 1'b0; #1;
    check("t6_rvalid", 128'(sb_rvalid_m0), 128'(1));
    check("t6_decerr_off", 128'(decerr_o), 128'(0));
    step();

    // Read and write decode errors together: two pulses.
    rq.push_back(32'hDEAD_BEEF); bq.push_back(1'b1);
    sb_araddr_m0 = 32'h3000_0000; sb_arvalid_m0 = 1'b1;
    sb_waddr_m0 = 32'h8000_0004; sb_wvalid_m0 = 1'b1; #1;
    check("t7_decerr_first", 128'(decerr_o), 128'(1));
    step(); sb_arvalid_m0 = 1'b0; sb_wvalid_m0 = 1'b0; #1;
    check("t7_decerr_second", 128'(decerr_o), 128'(1));
    step();
    check("t7_decerr_off", 128'(decerr_o), 128'(0));

    // Fill the write path to slave 3, then reset mid-flight.
    bhold[3] = 1'b1;
    wq.push_back({8'd3, 32'h4000_0000, 32'h1111_0001, 4'hF});
    sb_waddr_m0 = 32'h4000_0000; sb_wdata_m0 = 32'h1111_0001; sb_wstrb_m0 = 4'hF; sb_wvalid_m0 = 1'b1; #1;
    check("t8_w1_ready", 128'(sb_wready_m0), 128'(1));
    step();
    wq.push_back({8'd3, 32'h4000_0004, 32'h1111_0002, 4'hF});
    sb_waddr_m0 = 32'h4000_0004; sb_wdata_m0 = 32'h1111_0002; #1;
    check("t8_w2_ready", 128'(sb_wready_m0), 128'(1));
    step();
    sb_waddr_m0 = 32'h4000_0008; sb_wdata_m0 = 32'h1111_0003; #1;
    check("t8_full_wready", 128'(sb_wready_m0), 128'(0));
    bhold[3] = 1'b0; #1;
    check("t8_bvalid_pre", 128'(sb_bvalid_m0), 128'(1));
    rst = 1'b1; #1;
    check("t8_rst_bvalid", 128'(sb_bvalid_m0), 128'(0));
    check("t8_rst_wvalid_s", 128'(sb_wvalid_s), 128'(0));
    check("t8_rst_wready", 128'(sb_wready_m0), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    sb_wvalid_m0 = 1'b0; rst = 1'b0;
    step();
    bq.push_back(1'b0);
    wq.push_back({8'd3, 32'h4000_0000, 32'h3333_CAFE, 4'h3});
    sb_waddr_m0 = 32'h4000_0000; sb_wdata_m0 = 32'h3333_CAFE; sb_wstrb_m0 = 4'h3; sb_wvalid_m0 = 1'b1; #1;
    check("t8_post_wvalid_s", 128'(sb_wvalid_s), 128'(4'b1000));
    check("t8_post_wready", 128'(sb_wready_m0), 128'(1));
    step(); sb_wvalid_m0 = 1'b0;

    n = 0;
    while ((rq.size() != 0 || bq.size() != 0 || wq.size() != 0) && n < 50) begin
      step();
      n++;
    end
    check("drain_rd", 128'(rq.size()), 128'(0));
    check("drain_wr", 128'(bq.size()), 128'(0));
    check("drain_slv_wr", 128'(wq.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
